// File: rtl/mul_div_seq.sv
// Iterative RV32M multiply/divide unit: one-bit-per-cycle shift-add multiply and restoring divide.
// Operands are converted to magnitudes at acceptance; the sign fix-up lands with the last iteration.
module mul_div_seq #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ZERO_SKIP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      f3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned     CntW    = $clog2(XLEN) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0] cnt_q;
  logic [XLEN-1:0] acc_q;
  logic [XLEN-1:0] lo_q;
  logic [XLEN-1:0] op_q;
  logic [XLEN-1:0] a_q;
  logic [XLEN-1:0] result_q;
  logic [1:0]      fn_q;
  logic            neg_q;
  logic            rneg_q;
  logic            bz_q;

  logic            accept;
  logic            last;
  logic            a_signed;
  logic            b_signed;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic            skip;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_hi;
  logic [XLEN-1:0]   mul_lo;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   mul_res;
  logic [XLEN:0]     div_shift;
  logic [XLEN+1:0]   div_diff;
  logic              div_ge;
  logic [XLEN-1:0]   div_rem;
  logic [XLEN-1:0]   div_quo;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   div_res;
  logic              unused_diff;

  // Operand decode at acceptance
  always_comb begin
    a_signed = 1'b1;
    b_signed = 1'b1;
    case (f3)
      3'b010:                 b_signed = 1'b0;
      3'b011, 3'b101, 3'b111: begin
        a_signed = 1'b0;
        b_signed = 1'b0;
      end
      default: ;
    endcase
  end

  assign accept = start && ((state_q == StIdle) || (state_q == StDone));
  assign last   = (cnt_q == LastCnt);
  assign a_neg  = a_signed && srcA[XLEN-1];
  assign b_neg  = b_signed && srcB[XLEN-1];
  assign a_mag  = a_neg ? -srcA : srcA;
  assign b_mag  = b_neg ? -srcB : srcB;
  assign b_zero = (srcB == '0);
  assign skip   = (ZERO_SKIP != 0) && f3[2] && b_zero;

  // Multiply step: {acc, lo} holds the partial product, multiplier bits shift out of lo
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, op_q} : '0);
    mul_hi   = mul_sum[XLEN:1];
    mul_lo   = {mul_sum[0], lo_q[XLEN-1:1]};
    prod     = {mul_hi, mul_lo};
    prod_fix = neg_q ? -prod : prod;
    mul_res  = (fn_q == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  end

  // Restoring divide step: acc is the partial remainder, quotient bits shift into lo
  always_comb begin
    div_shift   = {acc_q, lo_q[XLEN-1]};
    div_diff    = {1'b0, div_shift} - {2'b00, op_q};
    div_ge      = ~div_diff[XLEN+1];
    div_rem     = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    div_quo     = {lo_q[XLEN-2:0], div_ge};
    quo_fix     = neg_q ? -div_quo : div_quo;
    rem_fix     = rneg_q ? -div_rem : div_rem;
    div_res     = bz_q ? (fn_q[1] ? a_q : '1) : (fn_q[1] ? rem_fix : quo_fix);
    unused_diff = div_diff[XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          if (skip) begin
            state_d = StDone;
          end else begin
            state_d = f3[2] ? StDiv : StMul;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StMul, StDiv: begin
        if (last) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy   = (state_q == StMul) || (state_q == StDiv);
    done   = (state_q == StDone);
    result = result_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      op_q     <= '0;
      a_q      <= '0;
      fn_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      bz_q     <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      lo_q   <= f3[2] ? a_mag : b_mag;
      op_q   <= f3[2] ? b_mag : a_mag;
      a_q    <= srcA;
      fn_q   <= f3[1:0];
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      bz_q   <= b_zero;
      if (skip) begin
        result_q <= f3[1] ? srcA : '1;
      end
    end else if (busy) begin
      // Counter returns to zero only alongside the exit to DONE
      cnt_q <= last ? '0 : cnt_q + 1'b1;
      if (state_q == StMul) begin
        acc_q <= mul_hi;
        lo_q  <= mul_lo;
        if (last) begin
          result_q <= mul_res;
        end
      end else begin
        acc_q <= div_rem;
        lo_q  <= div_quo;
        if (last) begin
          result_q <= div_res;
        end
      end
    end
  end

endmodule
